rr_tristate_bus_resolver: RTL and testbench
===========================================

Name: rr_tristate_bus_resolver

Overview:
- Parametrised successor to the gate-level multi-driver net blocks: resolves NCH candidate drivers onto one shared W-bit 4-state bus.
- Uses round-robin ownership with a hold limit and a break-before-make gap cycle.
- Bus floats to 'z when no channel owns it; X/Z content from the owning driver is detected and flagged.
- Sits between fuzz-generated driver modules and any consumer of a resolved net.

Parameters:
- NCH, 4, number of requesting channels (2..16)
- W, 8, bus data width in bits (1..64)
- HOLD_MAX, 4, max consecutive cycles one channel may own the bus (1..255)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NCH  per-channel bus request; bit i = channel i
- drv_data  input  NCH*W  channel i data on bits [i*W +: W]; 4-state
- grant  output  NCH  one-hot owner, all-zero when unowned
- bus_out  output  W  resolved bus (logic, 4-state); 'z when unowned
- bus_valid  output  1  high while bus_out carries owner data
- xz_err  output  1  sticky: owner data contained X or Z
- preempt_cnt  output  8  saturating count of hold-limit preemptions

Behaviour:
- Reset (async, immediate, mid-operation included): grant=0, bus_out='z, bus_valid=0, xz_err=0, preempt_cnt=0, state=IDLE, hold_cnt=0, last_owner=NCH-1, so channel 0 has top priority after reset.
- FSM states: IDLE, OWN, GAP.
- Winner selection: the first set req bit scanning upward from (last_owner+1) mod NCH, wrapping.
- IDLE:
  - If any req is set, go to OWN at this edge: grant<=onehot(winner), owner<=winner, last_owner<=winner, hold_cnt<=0, bus_out<=drv_data[winner], bus_valid<=1.
  - Otherwise stay in IDLE.
- OWN, at each edge:
  - If req[owner]==0, go to GAP.
  - Else if hold_cnt==HOLD_MAX-1, go to GAP and increment preempt_cnt (saturates at 255). This applies only when at least one other req bit is set; if the owner is the sole requester, hold_cnt stays at HOLD_MAX-1 and ownership continues.
  - Else hold_cnt++ and bus_out<=drv_data[owner].
- Entering GAP: grant<=0, bus_out<='z, bus_valid<=0.
- GAP lasts exactly 1 cycle. Then go to OWN with the new winner if any req is set (the previous owner is now lowest priority), else go to IDLE.
- Latency: grant, bus_out and bus_valid change together, at the same edge that samples req and drv_data. There is no extra pipeline stage.
- xz_err: set at any edge where OWN samples drv_data[owner] containing any X or Z bit. Cleared only by rst.
- Simultaneous requests: exactly one grant bit is ever set. req changes during GAP are sampled at the GAP exit edge.
- NCH=1: GAP still inserted on release, and the preemption rule never fires.

Optional Feature:
- Macro: RR_TRISTATE_BUS_RESOLVER_XZ_SCRUB_EN
- Defined:
  - bus_out replaces every X/Z bit of the sampled owner data with 0.
  - xz_err still sets as above.
  - Adds output xz_bit_cnt (16 bits, saturating) accumulating the number of scrubbed bits per OWN cycle; resets to 0.
- Undefined:
  - Owner data passes through unmodified, X/Z included.
  - No xz_bit_cnt port.

Test Plan (NCH=4, W=8, HOLD_MAX=4):
- Reset, then req=4'b0110 held, drv_data ch1=8'hA5, ch2=8'h3C.
  - grant=0010 for 4 cycles with bus_out=A5, then 1 GAP cycle (bus_out=zz, bus_valid=0).
  - Then grant=0100 for 4 cycles with bus_out=3C.
  - Then GAP, then back to ch1; preempt_cnt increments by 1 per switch.
- req=0001 only, held 10 cycles: grant=0001 continuously, bus_valid=1 throughout, preempt_cnt=0.
- ch0 owns and drops req after 2 cycles while req[3]=1: GAP for 1 cycle, then grant=1000; no preemption is counted.
- ch2 owns with drv_data=8'b1x0z_0000: xz_err=1 at the next edge and stays set after ch2 releases, until rst. Under the scrub macro, bus_out=8'b1000_0000 and xz_bit_cnt=2.
- Assert rst mid-OWN, asynchronously between edges: grant=0, bus_out=zz, bus_valid=0 immediately. After release with req=1111, grant=0001 first.
- Force 300 preemptions: preempt_cnt saturates at 255.

Source files
------------

// File: rtl/rr_tristate_bus_resolver.sv
// Round-robin resolver of NCH 4-state drivers onto one shared bus, with a hold limit and a one-cycle break-before-make gap.
// Optional build macro RR_TRISTATE_BUS_RESOLVER_XZ_SCRUB_EN: zero X/Z owner bits on the bus and count them on xz_bit_cnt.
module rr_tristate_bus_resolver #(
    parameter int NCH      = 4,
    parameter int W        = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic [NCH*W-1:0] drv_data,
    output logic [NCH-1:0]   grant,
    output logic [W-1:0]     bus_out,
    output logic             bus_valid,
    output logic             xz_err,
    output logic [7:0]       preempt_cnt
`ifdef RR_TRISTATE_BUS_RESOLVER_XZ_SCRUB_EN
    ,
    output logic [15:0]      xz_bit_cnt
`endif
);

    localparam int OW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [OW-1:0]  owner_reg, owner_next;
    logic [OW-1:0]  last_owner_reg, last_owner_next;
    logic [7:0]     hold_reg, hold_next;
    logic [NCH-1:0] grant_reg, grant_next;
    logic [W-1:0]   bus_data_reg, bus_data_next;
    logic           bus_valid_reg, bus_valid_next;
    logic           xz_err_reg, xz_err_next;
    logic [7:0]     preempt_reg, preempt_next;

    logic [W-1:0]   chan_data [NCH];
    logic [OW-1:0]  winner;
    logic [OW-1:0]  scan_idx;
    logic           winner_found;
    logic [OW-1:0]  load_idx;
    logic [W-1:0]   load_data;
    logic [W-1:0]   clean_data;
    logic [W-1:0]   xz_vec;
    logic           others_req;
    logic           own_sample;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            assign chan_data[gi] = drv_data[gi*W +: W];
        end
    endgenerate

    // Scan upward from the slot after the last owner, so the previous owner ends up last.
    always_comb begin
        winner       = '0;
        scan_idx     = '0;
        winner_found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            scan_idx = OW'((int'(last_owner_reg) + k) % NCH);
            if (!winner_found && req[scan_idx]) begin
                winner_found = 1'b1;
                winner       = scan_idx;
            end
        end
    end

    // While owning, the owner's lane feeds the bus; otherwise the candidate winner's lane does.
    assign load_idx   = (state_reg == OWN) ? owner_reg : winner;
    assign load_data  = chan_data[load_idx];
    assign others_req = |(req & ~grant_reg);

    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign xz_vec[gi] = (load_data[gi] !== 1'b0) && (load_data[gi] !== 1'b1);
`ifdef RR_TRISTATE_BUS_RESOLVER_XZ_SCRUB_EN
            assign clean_data[gi] = xz_vec[gi] ? 1'b0 : load_data[gi];
`else
            assign clean_data[gi] = load_data[gi];
`endif
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        hold_next       = hold_reg;
        grant_next      = grant_reg;
        bus_data_next   = bus_data_reg;
        bus_valid_next  = bus_valid_reg;
        xz_err_next     = xz_err_reg;
        preempt_next    = preempt_reg;
        own_sample      = 1'b0;

        case (state_reg)
            IDLE, GAP: begin
                if (|req) begin
                    state_next       = OWN;
                    owner_next       = winner;
                    last_owner_next  = winner;
                    hold_next        = 8'd0;
                    grant_next       = '0;
                    grant_next[winner] = 1'b1;
                    bus_data_next    = clean_data;
                    bus_valid_next   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            OWN: begin
                if (!req[owner_reg] || (hold_reg == HOLD_LAST && others_req)) begin
                    state_next     = GAP;
                    grant_next     = '0;
                    bus_valid_next = 1'b0;
                    if (req[owner_reg] && preempt_reg != 8'hFF)
                        preempt_next = preempt_reg + 8'd1;
                end else begin
                    // A sole requester keeps the bus with its hold count pinned at the limit.
                    if (hold_reg != HOLD_LAST)
                        hold_next = hold_reg + 8'd1;
                    bus_data_next  = clean_data;
                    bus_valid_next = 1'b1;
                    own_sample     = 1'b1;
                    if (|xz_vec)
                        xz_err_next = 1'b1;
                end
            end
            default: begin
                state_next     = IDLE;
                grant_next     = '0;
                bus_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= OW'(NCH - 1);
            hold_reg       <= 8'd0;
            grant_reg      <= '0;
            bus_data_reg   <= '0;
            bus_valid_reg  <= 1'b0;
            xz_err_reg     <= 1'b0;
            preempt_reg    <= 8'd0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            hold_reg       <= hold_next;
            grant_reg      <= grant_next;
            bus_data_reg   <= bus_data_next;
            bus_valid_reg  <= bus_valid_next;
            xz_err_reg     <= xz_err_next;
            preempt_reg    <= preempt_next;
        end
    end

`ifdef RR_TRISTATE_BUS_RESOLVER_XZ_SCRUB_EN
    localparam int PW = $clog2(W + 1);

    logic [PW-1:0] xz_pop;
    logic [16:0]   xz_sum;
    logic [15:0]   xz_cnt_reg, xz_cnt_next;

    always_comb begin
        xz_pop = '0;
        for (int b = 0; b < W; b++)
            xz_pop = xz_pop + PW'(xz_vec[b]);
        xz_sum      = {1'b0, xz_cnt_reg} + 17'(xz_pop);
        xz_cnt_next = xz_cnt_reg;
        if (own_sample)
            xz_cnt_next = xz_sum[16] ? 16'hFFFF : xz_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            xz_cnt_reg <= 16'd0;
        else
            xz_cnt_reg <= xz_cnt_next;
    end

    assign xz_bit_cnt = xz_cnt_reg;
`endif

    // The bus is released (floats) whenever no channel owns it, including during reset.
    assign bus_out     = bus_valid_reg ? bus_data_reg : {W{1'bz}};
    assign grant       = grant_reg;
    assign bus_valid   = bus_valid_reg;
    assign xz_err      = xz_err_reg;
    assign preempt_cnt = preempt_reg;

endmodule

// File: tb/tb_rr_tristate_bus_resolver.sv
// Directed bench for rr_tristate_bus_resolver (NCH=4, W=8, HOLD_MAX=4), one task per scenario.
module tb_rr_tristate_bus_resolver;

    localparam int NCH      = 4;
    localparam int W        = 8;
    localparam int HOLD_MAX = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   req;
    logic [NCH*W-1:0] drv_data;
    logic [NCH-1:0]   grant;
    wire  [W-1:0]     bus_out;
    logic             bus_valid;
    logic             xz_err;
    logic [7:0]       preempt_cnt;
`ifdef RR_TRISTATE_BUS_RESOLVER_XZ_SCRUB_EN
    logic [15:0]      xz_bit_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit four_state;

    rr_tristate_bus_resolver #(
        .NCH      (NCH),
        .W        (W),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .drv_data    (drv_data),
        .grant       (grant),
        .bus_out     (bus_out),
        .bus_valid   (bus_valid),
        .xz_err      (xz_err),
        .preempt_cnt (preempt_cnt)
`ifdef RR_TRISTATE_BUS_RESOLVER_XZ_SCRUB_EN
        ,
        .xz_bit_cnt  (xz_bit_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '0;
        drv_data = '0;
        #1;
        rst = 1'b1;
        #2;
        n_tests++;
        if (grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_grant: got %b expected 0000", grant);
        end
        n_tests++;
        if (bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", bus_valid);
        end
        n_tests++;
        if (xz_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_xz_err: got %b expected 0", xz_err);
        end
        n_tests++;
        if (preempt_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_preempt: got %0d expected 0", preempt_cnt);
        end
        if (four_state) begin
            n_tests++;
            if (bus_out !== 8'hzz) begin
                n_fail++;
                $display("FAIL reset_bus: got %h expected zz", bus_out);
            end
        end
        $display("[TB] reset: grant=%b valid=%b bus=%h", grant, bus_valid, bus_out);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [11] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                   4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0010};
        logic [7:0] exp_p [11] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2};
        logic [7:0] exp_d;
        logic       exp_v;
        do_reset();
        drv_data[1*W +: W] = 8'hA5;
        drv_data[2*W +: W] = 8'h3C;
        req = 4'b0110;
        for (int k = 0; k < 11; k++) begin
            tick();
            exp_v = (exp_g[k] != 4'b0000);
            exp_d = (exp_g[k] == 4'b0010) ? 8'hA5 : 8'h3C;
            $display("[TB] rr cycle %0d: grant=%b bus=%h valid=%b preempt=%0d",
                     k, grant, bus_out, bus_valid, preempt_cnt);
            n_tests++;
            if (grant !== exp_g[k]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", k, grant, exp_g[k]);
            end
            n_tests++;
            if (bus_valid !== exp_v) begin
                n_fail++;
                $display("FAIL rr_valid[%0d]: got %b expected %b", k, bus_valid, exp_v);
            end
            n_tests++;
            if (preempt_cnt !== exp_p[k]) begin
                n_fail++;
                $display("FAIL rr_preempt[%0d]: got %0d expected %0d", k, preempt_cnt, exp_p[k]);
            end
            if (exp_v) begin
                n_tests++;
                if (bus_out !== exp_d) begin
                    n_fail++;
                    $display("FAIL rr_bus[%0d]: got %h expected %h", k, bus_out, exp_d);
                end
            end else if (four_state) begin
                n_tests++;
                if (bus_out !== 8'hzz) begin
                    n_fail++;
                    $display("FAIL rr_bus_gap[%0d]: got %h expected zz", k, bus_out);
                end
            end
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_sole_owner();
        do_reset();
        drv_data[0 +: W] = 8'h5A;
        req = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            tick();
            $display("[TB] sole cycle %0d: grant=%b bus=%h valid=%b", k, grant, bus_out, bus_valid);
            n_tests++;
            if (grant !== 4'b0001 || bus_valid !== 1'b1 || bus_out !== 8'h5A) begin
                n_fail++;
                $display("FAIL sole_own[%0d]: got grant=%b valid=%b bus=%h expected grant=0001 valid=1 bus=5a",
                         k, grant, bus_valid, bus_out);
            end
        end
        n_tests++;
        if (preempt_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL sole_preempt: got %0d expected 0", preempt_cnt);
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_release();
        do_reset();
        drv_data[0*W +: W] = 8'h0F;
        drv_data[3*W +: W] = 8'hC3;
        req = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (grant !== 4'b0001 || bus_out !== 8'h0F) begin
                n_fail++;
                $display("FAIL rel_own0[%0d]: got grant=%b bus=%h expected grant=0001 bus=0f", k, grant, bus_out);
            end
        end
        req = 4'b1000;
        tick();
        $display("[TB] release gap: grant=%b valid=%b", grant, bus_valid);
        n_tests++;
        if (grant !== 4'b0000 || bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rel_gap: got grant=%b valid=%b expected grant=0000 valid=0", grant, bus_valid);
        end
        tick();
        $display("[TB] release next: grant=%b bus=%h", grant, bus_out);
        n_tests++;
        if (grant !== 4'b1000 || bus_out !== 8'hC3 || bus_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_next: got grant=%b bus=%h valid=%b expected grant=1000 bus=c3 valid=1",
                     grant, bus_out, bus_valid);
        end
        n_tests++;
        if (preempt_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rel_preempt: got %0d expected 0", preempt_cnt);
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_xz();
        logic [7:0] xz_val;
        logic [7:0] exp_bus;
        xz_val = 8'b1x0z_0000;
`ifdef RR_TRISTATE_BUS_RESOLVER_XZ_SCRUB_EN
        exp_bus = 8'b1000_0000;
`else
        exp_bus = 8'b1x0z_0000;
`endif
        do_reset();
        drv_data[2*W +: W] = xz_val;
        req = 4'b0100;
        tick();
        n_tests++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL xz_grant: got %b expected 0100", grant);
        end
        tick();
        $display("[TB] xz own: bus=%b xz_err=%b", bus_out, xz_err);
        if (four_state) begin
            n_tests++;
            if (xz_err !== 1'b1) begin
                n_fail++;
                $display("FAIL xz_set: got %b expected 1", xz_err);
            end
            n_tests++;
            if (bus_out !== exp_bus) begin
                n_fail++;
                $display("FAIL xz_bus: got %b expected %b", bus_out, exp_bus);
            end
`ifdef RR_TRISTATE_BUS_RESOLVER_XZ_SCRUB_EN
            n_tests++;
            if (xz_bit_cnt !== 16'd2) begin
                n_fail++;
                $display("FAIL xz_bit_cnt: got %0d expected 2", xz_bit_cnt);
            end
`endif
        end
        req = '0;
        drv_data[2*W +: W] = 8'h00;
        repeat (3) tick();
        if (four_state) begin
            n_tests++;
            if (xz_err !== 1'b1) begin
                n_fail++;
                $display("FAIL xz_sticky: got %b expected 1", xz_err);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        n_tests++;
        if (xz_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_xz_clear: got %b expected 0", xz_err);
        end
        drv_data[0*W +: W] = 8'h01;
        drv_data[1*W +: W] = 8'h11;
        req = 4'b0010;
        tick();
        tick();
        n_tests++;
        if (grant !== 4'b0010 || bus_out !== 8'h11) begin
            n_fail++;
            $display("FAIL ar_pre_own: got grant=%b bus=%h expected grant=0010 bus=11", grant, bus_out);
        end
        #2;
        rst = 1'b1;
        #1;
        $display("[TB] async reset: grant=%b valid=%b bus=%h", grant, bus_valid, bus_out);
        n_tests++;
        if (grant !== 4'b0000 || bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_immediate: got grant=%b valid=%b expected grant=0000 valid=0", grant, bus_valid);
        end
        if (four_state) begin
            n_tests++;
            if (bus_out !== 8'hzz) begin
                n_fail++;
                $display("FAIL ar_bus: got %h expected zz", bus_out);
            end
        end
        req = 4'b1111;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        $display("[TB] after reset: grant=%b bus=%h", grant, bus_out);
        n_tests++;
        if (grant !== 4'b0001 || bus_out !== 8'h01) begin
            n_fail++;
            $display("FAIL ar_first: got grant=%b bus=%h expected grant=0001 bus=01", grant, bus_out);
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_saturation();
        do_reset();
        req = 4'b0011;
        repeat (500) tick();
        $display("[TB] sat after 500 cycles: preempt=%0d", preempt_cnt);
        n_tests++;
        if (preempt_cnt !== 8'd100) begin
            n_fail++;
            $display("FAIL sat_100: got %0d expected 100", preempt_cnt);
        end
        repeat (770) tick();
        $display("[TB] sat after 1270 cycles: preempt=%0d", preempt_cnt);
        n_tests++;
        if (preempt_cnt !== 8'd254) begin
            n_fail++;
            $display("FAIL sat_254: got %0d expected 254", preempt_cnt);
        end
        repeat (5) tick();
        n_tests++;
        if (preempt_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_255: got %0d expected 255", preempt_cnt);
        end
        repeat (325) tick();
        $display("[TB] sat after 1600 cycles: preempt=%0d", preempt_cnt);
        n_tests++;
        if (preempt_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d expected 255", preempt_cnt);
        end
        req = '0;
        repeat (3) tick();
    endtask

    initial begin
        logic probe;
        probe = 1'bx;
        // A 4-state simulator keeps the X, so neither equality holds.
        if ((probe == 1'b0) || (probe == 1'b1))
            four_state = 1'b0;
        else
            four_state = 1'b1;
        test_reset();
        test_round_robin();
        test_sole_owner();
        test_release();
        test_xz();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
